// File: rtl/leaky_relu_core.sv
`default_nettype none
// ============================================================================
//  Module   : leaky_relu_core
//  Purpose  : Registered, streaming Leaky-ReLU activation for signed
//             fixed-point samples. Non-negative samples pass unchanged;
//             negative samples are scaled by alpha = A_NUM / A_DEN, rounded
//             toward -inf and clamped to the output range. One-clock latency,
//             one sample per clock, no backpressure.
//
//  Ports    : clk        in   1       rising-edge clock
//             rst        in   1       asynchronous active-high reset
//             in_data    in   DATA_W  signed input sample (two's complement)
//             in_valid   in   1       in_data qualifier
//             out_data   out  DATA_W  signed activated sample (registered)
//             out_valid  out  1       out_data qualifier (registered)
//
//  Params   : DATA_W  sample width
//             FRAC    fractional bits of the Q format (alpha is a pure ratio,
//                     so this does not change the arithmetic)
//             A_NUM   alpha numerator   (>= 0)
//             A_DEN   alpha denominator (>= 1)
//
//  Revision : 1.0  initial release
// ============================================================================
module leaky_relu_core #(
    parameter int DATA_W = 8,
    parameter int FRAC   = 4,
    parameter int A_NUM  = 1,
    parameter int A_DEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    // ------------------------------------------------------------------------
    // Arithmetic widths
    //   c_prod_w : width that holds x * A_NUM without overflow.
    //   c_calc_w : working width; extra headroom so that A_DEN and the
    //              quotient both fit as signed values in one common width.
    // ------------------------------------------------------------------------
    localparam int c_prod_w = DATA_W + $clog2(A_NUM + 1) + 1;
    localparam int c_calc_w = c_prod_w + $clog2(A_DEN + 1) + 1;

    localparam bit c_den_pow2 = ((A_DEN & (A_DEN - 1)) == 0);

    localparam logic signed [c_calc_w-1:0] c_num = c_calc_w'(A_NUM);

    // Largest / smallest representable output values at working width.
    localparam logic signed [c_calc_w-1:0] c_max =
        {{(c_calc_w - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [c_calc_w-1:0] c_min = ~c_max;

    // FRAC only documents the Q format of the stream.
    localparam logic [31:0] c_frac = 32'(FRAC);
    logic w_unused_frac;
    assign w_unused_frac = ^c_frac;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    logic signed [c_calc_w-1:0] w_x_ext;
    logic signed [c_calc_w-1:0] w_prod;
    logic signed [c_calc_w-1:0] w_quot;
    logic        [DATA_W-1:0]   w_neg_y;
    logic        [DATA_W-1:0]   w_y;

    assign w_x_ext = {{(c_calc_w - DATA_W){in_data[DATA_W-1]}}, in_data};
    assign w_prod  = w_x_ext * c_num;

    generate
        if (c_den_pow2) begin : g_pow2_div
            // An arithmetic right shift already floors toward -inf.
            localparam int c_shift = $clog2(A_DEN);
            assign w_quot = w_prod >>> c_shift;
        end else begin : g_gen_div
            // Native signed division truncates toward zero; step down by one
            // for negative products with a non-zero remainder to get floor.
            localparam logic signed [c_calc_w-1:0] c_den  = c_calc_w'(A_DEN);
            localparam logic signed [c_calc_w-1:0] c_one  = c_calc_w'(1);
            localparam logic signed [c_calc_w-1:0] c_zero = '0;

            logic signed [c_calc_w-1:0] w_trunc;
            logic signed [c_calc_w-1:0] w_rem;

            assign w_trunc = w_prod / c_den;
            assign w_rem   = w_prod % c_den;
            assign w_quot  = ((w_rem != c_zero) && (w_prod < c_zero))
                             ? (w_trunc - c_one) : w_trunc;
        end
    endgenerate

    // Clamp the scaled value into the output range. Only the lower clamp is
    // reachable in practice (negative input, non-negative alpha), but both
    // bounds are kept so the block stays correct for any parameter set.
    always_comb begin
        w_neg_y = w_quot[DATA_W-1:0];
        if (w_quot > c_max) begin
            w_neg_y = c_max[DATA_W-1:0];
        end else if (w_quot < c_min) begin
            w_neg_y = c_min[DATA_W-1:0];
        end
    end

    assign w_y = in_data[DATA_W-1] ? w_neg_y : in_data;

    // ------------------------------------------------------------------------
    // Output registers. out_valid follows in_valid every clock so that an
    // undefined in_data during idle cycles never reaches the qualifier;
    // out_data only loads on accepted samples and otherwise holds.
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out_data <= w_y;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_leaky_relu_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_leaky_relu_core
//  Purpose  : Self-checking bench for leaky_relu_core. Four instances with
//             different alpha ratios share one input stream:
//               0: 1/4  (power-of-two shift)
//               1: 3/2  (saturating)
//               2: 0/4  (negatives collapse to zero)
//               3: 5/3  (non-power-of-two divide with floor correction)
//             A behavioural model predicts every output each cycle; a table
//             of literal expectations pins the model on known values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_leaky_relu_core;

    localparam int N_DUT = 4;
    localparam int NUMS [N_DUT] = '{1, 3, 0, 5};
    localparam int DENS [N_DUT] = '{4, 2, 4, 3};

    logic              clk;
    logic              rst;
    logic signed [7:0] in_data;
    logic              in_valid;
    logic signed [7:0] od [N_DUT];
    logic              ov [N_DUT];

    leaky_relu_core #(.DATA_W(8), .FRAC(4), .A_NUM(1), .A_DEN(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(od[0]), .out_valid(ov[0]));
    leaky_relu_core #(.DATA_W(8), .FRAC(4), .A_NUM(3), .A_DEN(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(od[1]), .out_valid(ov[1]));
    leaky_relu_core #(.DATA_W(8), .FRAC(4), .A_NUM(0), .A_DEN(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(od[2]), .out_valid(ov[2]));
    leaky_relu_core #(.DATA_W(8), .FRAC(4), .A_NUM(5), .A_DEN(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(od[3]), .out_valid(ov[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------------
    // Reference: y = x for x >= 0, else floor(x*num/den) clamped to int8.
    // ------------------------------------------------------------------------
    function automatic int leaky(input int x, input int num, input int den);
        int p;
        int q;
        if (x >= 0) return x;
        p = x * num;
        q = p / den;
        if ((p % den) != 0 && p < 0) q = q - 1;
        if (q < -128) q = -128;
        if (q > 127)  q = 127;
        return q;
    endfunction

    // Expected outputs: one-sample delay, hold on idle, cleared by reset.
    int exp_d [N_DUT];
    int exp_v [N_DUT];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < N_DUT; k++) begin
            if (rst) begin
                exp_d[k] = 0;
                exp_v[k] = 0;
            end else begin
                exp_v[k] = in_valid ? 1 : 0;
                if (in_valid) exp_d[k] = leaky(int'(in_data), NUMS[k], DENS[k]);
            end
        end
    end

    // Literal expectations for DUTs 0..2, set by the stimulus process.
    logic [2:0] lit_mask;
    int         lit_d [3];
    int         lit_v;
    logic       probe;

    int checks;
    int failures;

    // Single compare process: runs every falling edge, plus on a probe pulse
    // used to look at the outputs between clock edges.
    always @(negedge clk or posedge probe) begin
        for (int k = 0; k < N_DUT; k++) begin
            int a;
            a = int'(od[k]);
            checks++;
            if (a != exp_d[k]) begin
                failures++;
                $display("FAIL model_data dut%0d t=%0t got=%0d want=%0d", k, $time, a, exp_d[k]);
            end
            checks++;
            if ((ov[k] ? 1 : 0) != exp_v[k]) begin
                failures++;
                $display("FAIL model_valid dut%0d t=%0t got=%0d want=%0d", k, $time, ov[k], exp_v[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (lit_mask[k]) begin
                int a;
                a = int'(od[k]);
                checks++;
                if (a != lit_d[k]) begin
                    failures++;
                    $display("FAIL lit_data dut%0d t=%0t got=%0d want=%0d", k, $time, a, lit_d[k]);
                end
                checks++;
                if ((ov[k] ? 1 : 0) != lit_v) begin
                    failures++;
                    $display("FAIL lit_valid dut%0d t=%0t got=%0d want=%0d", k, $time, ov[k], lit_v);
                end
            end
        end
    end

    // Directed table: row = sample driven; E* = output after it is accepted.
    localparam int NROW = 15;
    localparam int TV  [NROW] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    localparam int TX  [NROW] = '{16, 24, -16, -24, 0, 0, 127, -128, -1, -3, -4, -5, -100, -2, -50};
    localparam int TE0 [NROW] = '{16, 24, -4, -6, -6, 0, 127, -32, -1, -1, -1, -2, -25, -1, -13};
    localparam int TE1 [NROW] = '{16, 24, -24, -36, -36, 0, 127, -128, -2, -5, -6, -8, -128, -3, -75};
    localparam int TE2 [NROW] = '{16, 24, 0, 0, 0, 0, 127, 0, 0, 0, 0, 0, 0, 0, 0};

    task automatic set_lit(input int v, input int a, input int b, input int c);
        lit_mask = 3'b111;
        lit_v    = v;
        lit_d[0] = a;
        lit_d[1] = b;
        lit_d[2] = c;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        probe    = 1'b0;
        checks   = 0;
        failures = 0;
        lit_mask = 3'b000;
        lit_v    = 0;
        for (int k = 0; k < 3; k++) lit_d[k] = 0;

        // Reset state, checked at the falling edge inside the reset window.
        set_lit(0, 0, 0, 0);
        #20;
        rst = 1'b0;
        lit_mask = 3'b000;
        next_cycle();

        // Directed table.
        for (int i = 0; i < NROW; i++) begin
            in_valid = (TV[i] != 0);
            in_data  = (TV[i] != 0) ? 8'(TX[i]) : 8'hxx;
            if (i > 0) set_lit(TV[i-1], TE0[i-1], TE1[i-1], TE2[i-1]);
            next_cycle();
        end
        set_lit(TV[NROW-1], TE0[NROW-1], TE1[NROW-1], TE2[NROW-1]);
        in_valid = 1'b1;
        in_data  = 8'sd99;
        next_cycle();

        // Asynchronous reset mid-stream.
        set_lit(1, 99, 99, 99);
        in_data = -8'sd77;
        @(negedge clk);
        #1;
        rst = 1'b1;
        set_lit(0, 0, 0, 0);
        #1;
        probe = 1'b1;
        #1;
        probe = 1'b0;
        next_cycle();

        // Release and resume.
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'sd40;
        set_lit(0, 0, 0, 0);
        next_cycle();
        in_valid = 1'b0;
        set_lit(1, 40, 40, 40);
        next_cycle();
        lit_mask = 3'b000;

        // Randomized stream, checked against the model every cycle.
        for (int c = 0; c < 400; c++) begin
            int sel;
            in_valid = (($urandom % 4) != 0);
            sel      = int'($urandom % 8);
            case (sel)
                0:       in_data = -8'sd128;
                1:       in_data = 8'sd127;
                2:       in_data = -8'sd1;
                3:       in_data = 8'sd0;
                default: in_data = 8'($urandom);
            endcase
            if (c == 200) rst = 1'b1;
            if (c == 202) rst = 1'b0;
            next_cycle();
        end

        in_valid = 1'b0;
        repeat (3) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
